if_fetch_buf: RTL and testbench

- Instruction-fetch stage between the PC register and the IF/ID pipeline register.
- Each cycle it issues the current PC as a request on the instruction-memory bus.
- It pairs in-order read responses with their addresses and buffers them in a small FIFO, then presents instruction/address pairs to decode with a valid/ready handshake.
- When ctrl asserts a jump it flushes all buffered and in-flight fetches, and it back-pressures the PC register through fetch_hold_o.

---
 rtl/if_fetch_buf.sv | 110 +++++++++++
 tb/tb_if_fetch_buf.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buf.sv
// Instruction-fetch buffer: issues PC fetches under a credit limit, pairs in-order
// responses with their addresses and queues {addr, instr} for decode; jumps flush.
module if_fetch_buf #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        jump_flag_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_gnt_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        id_ready_i,
    output logic        fetch_hold_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   aq_mem_q   [DEPTH];
    logic [PW-1:0] aq_wptr_q, aq_rptr_q;
    logic [63:0]   fifo_mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [CW:0]   credit_used;
    logic          grant_acc;
    logic          resp_acc;
    logic          resp_keep;
    logic          pop;
    logic [63:0]   head;

    // Buffered entries consume credit too, so the FIFO can never overflow.
    assign credit_used  = {1'b0, out_q} + {1'b0, cnt_q};
    assign rom_req_o    = rst_n && !jump_flag_i && (credit_used < (CW+1)'(DEPTH));
    assign rom_addr_o   = pc_i;
    assign grant_acc    = rom_req_o && rom_gnt_i;
    assign fetch_hold_o = !grant_acc && !jump_flag_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_acc  = rom_rvalid_i && (out_q != '0);
    assign resp_keep = resp_acc && !jump_flag_i && (drop_q == '0);

    assign inst_valid_o = (cnt_q != '0);
    assign pop          = inst_valid_o && id_ready_i && !jump_flag_i;
    assign head         = fifo_mem_q[rptr_q];
    assign inst_o       = inst_valid_o ? head[31:0]  : NOP_INST;
    assign inst_addr_o  = inst_valid_o ? head[63:32] : 32'h0;

    always_comb begin
        out_d  = out_q + CW'(grant_acc) - CW'(resp_acc);
        drop_d = drop_q;
        cnt_d  = cnt_q + CW'(resp_keep) - CW'(pop);
        if (jump_flag_i) begin
            drop_d = out_q - CW'(resp_acc);
            cnt_d  = '0;
        end else if (resp_acc && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq_wptr_q <= '0;
            aq_rptr_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            out_q     <= '0;
            drop_q    <= '0;
            cnt_q     <= '0;
        end else begin
            out_q  <= out_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
            if (grant_acc) begin
                aq_wptr_q <= aq_wptr_q + PW'(1);
            end
            if (resp_acc) begin
                aq_rptr_q <= aq_rptr_q + PW'(1);
            end
            if (resp_keep) begin
                wptr_q <= wptr_q + PW'(1);
            end
            // On a flush nothing is written, so aligning the read pointer empties the FIFO.
            if (jump_flag_i) begin
                rptr_q <= wptr_q;
            end else if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant_acc) begin
            aq_mem_q[aq_wptr_q] <= pc_i;
        end
        if (resp_keep) begin
            fifo_mem_q[wptr_q] <= {aq_mem_q[aq_rptr_q], rom_rdata_i};
        end
    end

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf (DEPTH=2) with an in-order, latency-1 memory model.
module tb_if_fetch_buf;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        jump_flag_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        id_ready_i;
    logic        fetch_hold_o;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] mem_q[$];
    bit          mem_en;

    if_fetch_buf #(.DEPTH(2), .NOP_INST(NOP)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc_i),
        .jump_flag_i  (jump_flag_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .id_ready_i   (id_ready_i),
        .fetch_hold_o (fetch_hold_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // One clock: record a grant, advance PC on it, then (if enabled) return the oldest request.
    task automatic step();
        logic        fire;
        logic [31:0] a;
        fire = rom_req_o && rom_gnt_i;
        if (fire) mem_q.push_back(rom_addr_o);
        @(posedge clk);
        #1;
        if (fire) pc_i = pc_i + 32'd4;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = 32'h0;
        if (mem_en && mem_q.size() > 0) begin
            a = mem_q.pop_front();
            rom_rvalid_i = 1'b1;
            rom_rdata_i  = rdata_of(a);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        jump_flag_i  = 1'b0;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = 32'h0;
        rom_gnt_i    = 1'b0;
        id_ready_i   = 1'b0;
        pc_i         = 32'h0;
        mem_en       = 1'b1;
        mem_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; jump_flag_i = 1'b0; rom_gnt_i = 1'b1; rom_rvalid_i = 1'b0;
        rom_rdata_i = 32'h0; id_ready_i = 1'b1; pc_i = 32'h0; mem_en = 1'b1;
        @(negedge clk); #1;
        vec_cnt++; if (rom_req_o !== 1'b0) begin err_cnt++; $display("FAIL rst_req: got %b want 0", rom_req_o); end
        vec_cnt++; if (inst_valid_o !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", inst_valid_o); end
        vec_cnt++; if (inst_o !== NOP) begin err_cnt++; $display("FAIL rst_inst: got %h want %h", inst_o, NOP); end
        vec_cnt++; if (inst_addr_o !== 32'h0) begin err_cnt++; $display("FAIL rst_addr: got %h want 0", inst_addr_o); end
        vec_cnt++; if (fetch_hold_o !== 1'b1) begin err_cnt++; $display("FAIL rst_hold: got %b want 1", fetch_hold_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr [2];
        int k;
        exp_addr[0] = 32'h4; exp_addr[1] = 32'h8; k = 0;
        do_reset();
        id_ready_i = 1'b1; rom_gnt_i = 1'b1; #1;
        vec_cnt++; if (rom_req_o !== 1'b1) begin err_cnt++; $display("FAIL s_req_c0: got %b want 1", rom_req_o); end
        vec_cnt++; if (fetch_hold_o !== 1'b0) begin err_cnt++; $display("FAIL s_hold_c0: got %b want 0", fetch_hold_o); end
        vec_cnt++; if (rom_addr_o !== 32'h0) begin err_cnt++; $display("FAIL s_addr_c0: got %h want 0", rom_addr_o); end
        step();
        vec_cnt++; if (rom_req_o !== 1'b1 || fetch_hold_o !== 1'b0) begin err_cnt++; $display("FAIL s_req_c1: got req=%b hold=%b want req=1 hold=0", rom_req_o, fetch_hold_o); end
        vec_cnt++; if (inst_valid_o !== 1'b0) begin err_cnt++; $display("FAIL s_valid_c1: got %b want 0", inst_valid_o); end
        step();
        vec_cnt++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== rdata_of(32'h0)) begin
            err_cnt++; $display("FAIL s_head_c2: got v=%b a=%h i=%h want v=1 a=0 i=%h", inst_valid_o, inst_addr_o, inst_o, rdata_of(32'h0)); end
        vec_cnt++; if (rom_req_o !== 1'b0 || fetch_hold_o !== 1'b1) begin err_cnt++; $display("FAIL s_credit_c2: got req=%b hold=%b want req=0 hold=1", rom_req_o, fetch_hold_o); end
        step();
        for (int i = 0; i < 12; i++) begin
            rom_gnt_i = (pc_i < 32'd12);
            #1;
            if (inst_valid_o === 1'b1) begin
                vec_cnt++;
                if (k > 1 || inst_addr_o !== exp_addr[k > 1 ? 1 : k] || inst_o !== rdata_of(exp_addr[k > 1 ? 1 : k])) begin
                    err_cnt++; $display("FAIL s_order_%0d: got a=%h i=%h want a=%h", k, inst_addr_o, inst_o, exp_addr[k > 1 ? 1 : k]);
                end
                k++;
            end
            step();
        end
        vec_cnt++; if (k != 2) begin err_cnt++; $display("FAIL s_count: got %0d deliveries want 2", k); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rom_gnt_i = 1'b1; #1;
        step();
        vec_cnt++; if (rom_req_o !== 1'b1 || fetch_hold_o !== 1'b0) begin err_cnt++; $display("FAIL bp_c1: got req=%b hold=%b want 1/0", rom_req_o, fetch_hold_o); end
        step();
        vec_cnt++; if (rom_req_o !== 1'b0 || fetch_hold_o !== 1'b1) begin err_cnt++; $display("FAIL bp_c2: got req=%b hold=%b want 0/1", rom_req_o, fetch_hold_o); end
        vec_cnt++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin err_cnt++; $display("FAIL bp_head_c2: got v=%b a=%h want 1/0", inst_valid_o, inst_addr_o); end
        step();
        id_ready_i = 1'b1; #1;
        vec_cnt++; if (rom_req_o !== 1'b0 || fetch_hold_o !== 1'b1 || inst_addr_o !== 32'h0) begin
            err_cnt++; $display("FAIL bp_full_c3: got req=%b hold=%b a=%h want 0/1/0", rom_req_o, fetch_hold_o, inst_addr_o); end
        step();
        id_ready_i = 1'b0; #1;
        vec_cnt++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h4) begin err_cnt++; $display("FAIL bp_pop_c4: got v=%b a=%h want 1/4", inst_valid_o, inst_addr_o); end
        vec_cnt++; if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h8 || fetch_hold_o !== 1'b0) begin
            err_cnt++; $display("FAIL bp_req8_c4: got req=%b addr=%h hold=%b want 1/8/0", rom_req_o, rom_addr_o, fetch_hold_o); end
        step();
        vec_cnt++; if (rom_req_o !== 1'b0 || fetch_hold_o !== 1'b1) begin err_cnt++; $display("FAIL bp_one_c5: got req=%b hold=%b want 0/1", rom_req_o, fetch_hold_o); end
        step();
        vec_cnt++; if (inst_addr_o !== 32'h4 || rom_req_o !== 1'b0) begin err_cnt++; $display("FAIL bp_c6: got a=%h req=%b want 4/0", inst_addr_o, rom_req_o); end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        pc_i = 32'h10; id_ready_i = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            vec_cnt++; if (rom_req_o !== 1'b1 || fetch_hold_o !== 1'b1 || rom_addr_o !== 32'h10) begin
                err_cnt++; $display("FAIL gs_stall_%0d: got req=%b hold=%b addr=%h want 1/1/10", i, rom_req_o, fetch_hold_o, rom_addr_o); end
            step();
        end
        rom_gnt_i = 1'b1; #1;
        vec_cnt++; if (fetch_hold_o !== 1'b0 || rom_addr_o !== 32'h10) begin err_cnt++; $display("FAIL gs_grant: got hold=%b addr=%h want 0/10", fetch_hold_o, rom_addr_o); end
        step();
        rom_gnt_i = 1'b0; #1;
        vec_cnt++; if (inst_valid_o !== 1'b0) begin err_cnt++; $display("FAIL gs_c4: got %b want 0", inst_valid_o); end
        step();
        vec_cnt++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h10 || inst_o !== rdata_of(32'h10)) begin
            err_cnt++; $display("FAIL gs_deliver: got v=%b a=%h i=%h want 1/10/%h", inst_valid_o, inst_addr_o, inst_o, rdata_of(32'h10)); end
        step();
        vec_cnt++; if (inst_valid_o !== 1'b0) begin err_cnt++; $display("FAIL gs_single: got %b want 0", inst_valid_o); end
    endtask

    task automatic test_jump_flush();
        int seen;
        do_reset();
        rom_gnt_i = 1'b1; #1;
        step();
        mem_en = 1'b0;
        step();
        vec_cnt++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin err_cnt++; $display("FAIL jf_buf: got v=%b a=%h want 1/0", inst_valid_o, inst_addr_o); end
        jump_flag_i = 1'b1; #1;
        vec_cnt++; if (rom_req_o !== 1'b0 || fetch_hold_o !== 1'b0) begin err_cnt++; $display("FAIL jf_jump: got req=%b hold=%b want 0/0", rom_req_o, fetch_hold_o); end
        step();
        jump_flag_i = 1'b0; pc_i = 32'h100; mem_en = 1'b1; id_ready_i = 1'b1; #1;
        vec_cnt++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin err_cnt++; $display("FAIL jf_flushed: got v=%b i=%h want 0/%h", inst_valid_o, inst_o, NOP); end
        step();
        rom_gnt_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (inst_valid_o === 1'b1) begin
                vec_cnt++;
                if (seen != 0 || inst_addr_o !== 32'h100 || inst_o !== rdata_of(32'h100)) begin
                    err_cnt++; $display("FAIL jf_target_%0d: got a=%h i=%h want a=100 i=%h", seen, inst_addr_o, inst_o, rdata_of(32'h100));
                end
                seen++;
            end
            step();
        end
        vec_cnt++; if (seen != 1) begin err_cnt++; $display("FAIL jf_count: got %0d deliveries want 1", seen); end
    endtask

    task automatic test_jump_with_rvalid();
        int seen;
        do_reset();
        pc_i = 32'h8; id_ready_i = 1'b1; rom_gnt_i = 1'b1; mem_en = 1'b0; #1;
        step();
        step();
        rom_gnt_i = 1'b0; mem_en = 1'b1;
        step();
        mem_en = 1'b0;
        jump_flag_i = 1'b1; #1;
        vec_cnt++; if (rom_rvalid_i !== 1'b1 || inst_valid_o !== 1'b0) begin err_cnt++; $display("FAIL jr_setup: got rvalid=%b v=%b want 1/0", rom_rvalid_i, inst_valid_o); end
        step();
        jump_flag_i = 1'b0; pc_i = 32'h200; rom_gnt_i = 1'b1; mem_en = 1'b1; #1;
        vec_cnt++; if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h200 || inst_valid_o !== 1'b0) begin
            err_cnt++; $display("FAIL jr_req: got req=%b addr=%h v=%b want 1/200/0", rom_req_o, rom_addr_o, inst_valid_o); end
        step();
        rom_gnt_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (inst_valid_o === 1'b1) begin
                vec_cnt++;
                if (seen != 0 || inst_addr_o !== 32'h200) begin
                    err_cnt++; $display("FAIL jr_target_%0d: got a=%h want a=200", seen, inst_addr_o);
                end
                seen++;
            end
            step();
        end
        vec_cnt++; if (seen != 1) begin err_cnt++; $display("FAIL jr_count: got %0d deliveries want 1", seen); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rom_gnt_i = 1'b1; #1;
        repeat (4) step();
        vec_cnt++; if (inst_valid_o !== 1'b1 || rom_req_o !== 1'b0) begin err_cnt++; $display("FAIL rm_full: got v=%b req=%b want 1/0", inst_valid_o, rom_req_o); end
        rst_n = 1'b0; #1;
        vec_cnt++; if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0 || rom_req_o !== 1'b0) begin
            err_cnt++; $display("FAIL rm_async: got v=%b i=%h a=%h req=%b want 0/%h/0/0", inst_valid_o, inst_o, inst_addr_o, rom_req_o, NOP); end
        mem_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1; pc_i = 32'h0; id_ready_i = 1'b1;
        rom_rvalid_i = 1'b1; rom_rdata_i = 32'hDEAD_BEEF; #1;
        vec_cnt++; if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h0) begin err_cnt++; $display("FAIL rm_resume: got req=%b addr=%h want 1/0", rom_req_o, rom_addr_o); end
        step();
        vec_cnt++; if (inst_valid_o !== 1'b0) begin err_cnt++; $display("FAIL rm_stale: got %b want 0", inst_valid_o); end
        step();
        vec_cnt++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== rdata_of(32'h0)) begin
            err_cnt++; $display("FAIL rm_first: got v=%b a=%h i=%h want 1/0/%h", inst_valid_o, inst_addr_o, inst_o, rdata_of(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_jump_flush();
        test_jump_with_rvalid();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
